pipe_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. Drives the write-enable and clear inputs of the PC and of the IF/ID, ID/EX and downstream pipeline registers. It resolves three kinds of event:
- Tuse/Tnew data hazards.
- Mult/div unit occupancy, tracked by an internal busy countdown.
- Exception/interrupt flushes and branch-likely nullification.

It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_hazard_ctrl_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 73 +++++++
 tb/tb_pipe_hazard_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-side status in, stall/flush controls out.
// The pipeline side is the master; the controller is the slave.
interface pipe_hazard_ctrl_if;
    logic [4:0]  D_rs;
    logic [4:0]  D_rt;
    logic [1:0]  D_Tuse_rs;
    logic [1:0]  D_Tuse_rt;
    logic [4:0]  E_A3;
    logic [1:0]  E_Tnew;
    logic [4:0]  M_A3;
    logic [1:0]  M_Tnew;
    logic        D_md_use;
    logic        E_md_start;
    logic        E_md_is_div;
    logic        D_eret;
    logic        E_mtc0_epc;
    logic        M_mtc0_epc;
    logic        D_likely_null;
    logic        int_req;
    logic        PC_WE;
    logic        IFID_WE;
    logic        IFID_clr;
    logic        IDEX_clr;
    logic        flush_all;
    logic        md_busy;
    logic [31:0] stall_cycles;

    modport master (
        output D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew,
               D_md_use, E_md_start, E_md_is_div, D_eret, E_mtc0_epc,
               M_mtc0_epc, D_likely_null, int_req,
        input  PC_WE, IFID_WE, IFID_clr, IDEX_clr, flush_all, md_busy,
               stall_cycles
    );

    modport slave (
        input  D_rs, D_rt, D_Tuse_rs, D_Tuse_rt, E_A3, E_Tnew, M_A3, M_Tnew,
               D_md_use, E_md_start, E_md_is_div, D_eret, E_mtc0_epc,
               M_mtc0_epc, D_likely_null, int_req,
        output PC_WE, IFID_WE, IFID_clr, IDEX_clr, flush_all, md_busy,
               stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: Tuse/Tnew hazards,
// mult/div occupancy, eret/EPC ordering, exception flush and likely-nullify.
module pipe_hazard_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    pipe_hazard_ctrl_if.slave  hz
);

    logic [CNT_W-1:0] cnt;
    logic             stall_rs;
    logic             stall_rt;
    logic             stall_md;
    logic             stall_eret;
    logic             stall;
    logic             busy;

    always_comb begin
        stall_rs = (hz.D_rs != 5'd0) &&
                   (((hz.E_A3 == hz.D_rs) && (hz.D_Tuse_rs < hz.E_Tnew)) ||
                    ((hz.M_A3 == hz.D_rs) && (hz.D_Tuse_rs < hz.M_Tnew)));
        stall_rt = (hz.D_rt != 5'd0) &&
                   (((hz.E_A3 == hz.D_rt) && (hz.D_Tuse_rt < hz.E_Tnew)) ||
                    ((hz.M_A3 == hz.D_rt) && (hz.D_Tuse_rt < hz.M_Tnew)));
        busy       = (cnt != '0) || hz.E_md_start;
        stall_md   = hz.D_md_use && busy;
        stall_eret = hz.D_eret && (hz.E_mtc0_epc || hz.M_mtc0_epc);
        stall      = (stall_rs || stall_rt || stall_md || stall_eret) && !hz.int_req;
    end

    // Priority: exception flush, then stall, then likely-nullify.
    always_comb begin
        hz.PC_WE     = 1'b1;
        hz.IFID_WE   = 1'b1;
        hz.IFID_clr  = 1'b0;
        hz.IDEX_clr  = 1'b0;
        hz.flush_all = 1'b0;
        hz.md_busy   = busy;
        if (hz.int_req) begin
            hz.flush_all = 1'b1;
        end else if (stall) begin
            hz.PC_WE    = 1'b0;
            hz.IFID_WE  = 1'b0;
            hz.IDEX_clr = 1'b1;
        end else if (hz.D_likely_null) begin
            hz.IFID_clr = 1'b1;
        end
    end

    // A start cancelled by an exception does not load, but a running count
    // keeps draining since HI/LO are committed by the unit regardless.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt <= '0;
        end else if (hz.E_md_start && !hz.int_req) begin
            cnt <= hz.E_md_is_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hz.stall_cycles <= '0;
        end else if (stall && (hz.stall_cycles != '1)) begin
            hz.stall_cycles <= hz.stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed checks for pipe_hazard_ctrl with hand-computed expectations.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;

    pipe_hazard_ctrl_if hz();

    pipe_hazard_ctrl #(
        .MULT_CYC (5),
        .DIV_CYC  (10),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        hz.D_rs = '0;          hz.D_rt = '0;
        hz.D_Tuse_rs = 2'd3;   hz.D_Tuse_rt = 2'd3;
        hz.E_A3 = '0;          hz.E_Tnew = '0;
        hz.M_A3 = '0;          hz.M_Tnew = '0;
        hz.D_md_use = 1'b0;    hz.E_md_start = 1'b0;  hz.E_md_is_div = 1'b0;
        hz.D_eret = 1'b0;      hz.E_mtc0_epc = 1'b0;  hz.M_mtc0_epc = 1'b0;
        hz.D_likely_null = 1'b0; hz.int_req = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        do_reset();
        #1;
        chk("rst_PC_WE", hz.PC_WE, 1);
        chk("rst_IFID_WE", hz.IFID_WE, 1);
        chk("rst_IFID_clr", hz.IFID_clr, 0);
        chk("rst_IDEX_clr", hz.IDEX_clr, 0);
        chk("rst_flush", hz.flush_all, 0);
        chk("rst_md_busy", hz.md_busy, 0);
        chk("rst_stall_cycles", hz.stall_cycles, 0);

        // Load-use on rs
        hz.E_A3 = 5'd8; hz.E_Tnew = 2'd2; hz.D_rs = 5'd8; hz.D_Tuse_rs = 2'd1;
        #1;
        chk("lu_PC_WE", hz.PC_WE, 0);
        chk("lu_IFID_WE", hz.IFID_WE, 0);
        chk("lu_IDEX_clr", hz.IDEX_clr, 1);
        tick();
        chk("lu_stall_cycles", hz.stall_cycles, 1);
        hz.D_rs = 5'd0;
        #1;
        chk("lu_r0_PC_WE", hz.PC_WE, 1);
        chk("lu_r0_IDEX_clr", hz.IDEX_clr, 0);
        hz.D_rs = 5'd8; hz.D_Tuse_rs = 2'd2;
        #1;
        chk("lu_equal_tnew_PC_WE", hz.PC_WE, 1);
        hz.D_rt = 5'd8; hz.D_Tuse_rt = 2'd0;
        #1;
        chk("rt_hazard_PC_WE", hz.PC_WE, 0);
        tick();
        chk("rt_stall_cycles", hz.stall_cycles, 2);

        // Mult then mflo
        do_reset();
        hz.D_md_use = 1'b1; hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            #1;
            chk($sformatf("mult_PC_WE_c%0d", c), hz.PC_WE, (c == 6) ? 1 : 0);
            chk($sformatf("mult_busy_c%0d", c), hz.md_busy, (c == 6) ? 0 : 1);
            tick();
            hz.E_md_start = 1'b0;
        end
        chk("mult_stall_cycles", hz.stall_cycles, 6);

        // Div repeat
        do_reset();
        hz.D_md_use = 1'b1; hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        for (int c = 0; c <= 11; c++) begin
            #1;
            chk($sformatf("div_PC_WE_c%0d", c), hz.PC_WE, (c == 11) ? 1 : 0);
            tick();
            hz.E_md_start = 1'b0;
        end
        chk("div_stall_cycles", hz.stall_cycles, 11);

        // Exception cancels a div start and overrides an rt hazard
        do_reset();
        hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        hz.D_rt = 5'd5; hz.E_A3 = 5'd5; hz.D_Tuse_rt = 2'd0; hz.E_Tnew = 2'd1;
        hz.int_req = 1'b1;
        #1;
        chk("int_flush", hz.flush_all, 1);
        chk("int_PC_WE", hz.PC_WE, 1);
        chk("int_IFID_WE", hz.IFID_WE, 1);
        chk("int_IDEX_clr", hz.IDEX_clr, 0);
        tick();
        idle();
        #1;
        chk("int_md_busy_after", hz.md_busy, 0);
        chk("int_stall_cycles", hz.stall_cycles, 0);
        hz.D_md_use = 1'b1;
        #1;
        chk("int_no_md_stall", hz.PC_WE, 1);
        hz.D_md_use = 1'b0;

        // Branch-likely nullify
        hz.D_likely_null = 1'b1;
        #1;
        chk("null_IFID_clr", hz.IFID_clr, 1);
        chk("null_IFID_WE", hz.IFID_WE, 1);
        chk("null_PC_WE", hz.PC_WE, 1);
        hz.M_A3 = 5'd3; hz.M_Tnew = 2'd1; hz.D_rs = 5'd3; hz.D_Tuse_rs = 2'd0;
        #1;
        chk("null_haz_IFID_clr", hz.IFID_clr, 0);
        chk("null_haz_IDEX_clr", hz.IDEX_clr, 1);

        // eret behind mtc0 EPC
        do_reset();
        hz.D_eret = 1'b1; hz.M_mtc0_epc = 1'b1;
        #1;
        chk("eret_m_c0", hz.PC_WE, 0);
        tick();
        hz.M_mtc0_epc = 1'b0;
        #1;
        chk("eret_m_c1", hz.PC_WE, 1);
        hz.E_mtc0_epc = 1'b1;
        #1;
        chk("eret_e_c0", hz.PC_WE, 0);
        tick();
        hz.E_mtc0_epc = 1'b0; hz.M_mtc0_epc = 1'b1;
        #1;
        chk("eret_e_c1", hz.PC_WE, 0);
        tick();
        hz.M_mtc0_epc = 1'b0;
        #1;
        chk("eret_e_c2", hz.PC_WE, 1);
        chk("eret_stall_cycles", hz.stall_cycles, 3);

        // Reset in the middle of a div countdown
        do_reset();
        hz.D_md_use = 1'b1; hz.E_md_start = 1'b1; hz.E_md_is_div = 1'b1;
        tick();
        hz.E_md_start = 1'b0;
        tick();
        tick();
        chk("mid_stall_cycles_pre", hz.stall_cycles, 3);
        chk("mid_busy_pre", hz.md_busy, 1);
        hz.D_md_use = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        chk("mid_busy_post", hz.md_busy, 0);
        chk("mid_stall_cycles_post", hz.stall_cycles, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule
